// File: rtl/tetris_cmd_scheduler.sv
// Tetris command scheduler: merges gravity drops, button commands and UART
// commands into the single one-cycle ctrl stream consumed by the tetris core.
// Gravity wins over user sources; button and UART share round-robin.
// Optional build macro SCHED_SOFT_DROP_EN adds a soft_drop input that forces
// the fastest gravity period while held.
module tetris_cmd_scheduler #(
    parameter int unsigned      CMD_W     = 4,
    parameter logic [CMD_W-1:0] DROP_CODE = CMD_W'(3),
    parameter int unsigned      TICK_BASE = 25000000,
    parameter int unsigned      TICK_STEP = 2000000,
    parameter int unsigned      TICK_MIN  = 2500000
) (
    input  logic             clk_50MHz,
    input  logic             reset_n,
    input  logic             run,
    input  logic             ready,
    input  logic [3:0]       level,
`ifdef SCHED_SOFT_DROP_EN
    input  logic             soft_drop,
`endif
    input  logic             btn_valid,
    input  logic [CMD_W-1:0] btn_cmd,
    input  logic             uart_valid,
    input  logic [CMD_W-1:0] uart_cmd,
    output logic [CMD_W-1:0] ctrl,
    output logic [1:0]       grant_src,
    output logic             busy,
    output logic [7:0]       drop_cnt
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT
    } state_t;

    localparam logic [1:0] SRC_GRAV = 2'b01;
    localparam logic [1:0] SRC_BTN  = 2'b10;
    localparam logic [1:0] SRC_UART = 2'b11;

    state_t state, next_state;

    logic [31:0]      level_sub;
    logic [31:0]      period;
    logic [31:0]      timer;
    logic             timer_fire;
    logic             grav_pend;

    logic             btn_full;
    logic [CMD_W-1:0] btn_code;
    logic             uart_full;
    logic [CMD_W-1:0] uart_code;
    logic             rr_uart;

    logic             grant_grav;
    logic             grant_btn;
    logic             grant_uart;
    logic             grant_any;

    logic             btn_req;
    logic             uart_req;
    logic             btn_drop;
    logic             uart_drop;
    logic [8:0]       drop_sum;

    logic [CMD_W-1:0] cmd_q;

    // Drop period shrinks with level but never below the floor; guard the subtraction against underflow
    always_comb begin
        level_sub = 32'(level) * TICK_STEP;
        if ((level_sub < TICK_BASE) && ((TICK_BASE - level_sub) > TICK_MIN)) begin
            period = TICK_BASE - level_sub;
        end else begin
            period = TICK_MIN;
        end
`ifdef SCHED_SOFT_DROP_EN
        if (soft_drop) begin
            period = TICK_MIN;
        end
`endif
    end

    // Using >= lets a level change that shrinks the period below the current count fire immediately
    assign timer_fire = (timer >= (period - 32'd1));

    // Gravity timer and pending bit; a fire while still pending simply coalesces
    always_ff @(posedge clk_50MHz) begin
        if (!reset_n || !run) begin
            timer     <= 32'd0;
            grav_pend <= 1'b0;
        end else begin
            timer     <= timer_fire ? 32'd0 : timer + 32'd1;
            grav_pend <= timer_fire | (grav_pend & ~grant_grav);
        end
    end

    assign btn_req   = btn_valid && (btn_cmd != '0);
    assign uart_req  = uart_valid && (uart_cmd != '0);
    assign btn_drop  = btn_req && btn_full && !grant_btn;
    assign uart_drop = uart_req && uart_full && !grant_uart;
    assign drop_sum  = {1'b0, drop_cnt} + {8'd0, btn_drop} + {8'd0, uart_drop};

    // User request slots: a slot freed by this cycle's grant may refill in the same cycle
    always_ff @(posedge clk_50MHz) begin
        if (!reset_n) begin
            btn_full  <= 1'b0;
            btn_code  <= '0;
            uart_full <= 1'b0;
            uart_code <= '0;
            drop_cnt  <= 8'd0;
        end else begin
            if (btn_req && (!btn_full || grant_btn)) begin
                btn_full <= 1'b1;
                btn_code <= btn_cmd;
            end else if (grant_btn) begin
                btn_full <= 1'b0;
            end
            if (uart_req && (!uart_full || grant_uart)) begin
                uart_full <= 1'b1;
                uart_code <= uart_cmd;
            end else if (grant_uart) begin
                uart_full <= 1'b0;
            end
            drop_cnt <= drop_sum[8] ? 8'hFF : drop_sum[7:0];
        end
    end

    // Granted command, its source and the round-robin pointer are latched at the grant edge
    always_ff @(posedge clk_50MHz) begin
        if (!reset_n) begin
            cmd_q     <= '0;
            grant_src <= 2'b00;
            rr_uart   <= 1'b0;
        end else if (grant_any) begin
            if (grant_grav) begin
                cmd_q     <= DROP_CODE;
                grant_src <= SRC_GRAV;
            end else if (grant_btn) begin
                cmd_q     <= btn_code;
                grant_src <= SRC_BTN;
                rr_uart   <= 1'b1;
            end else begin
                cmd_q     <= uart_code;
                grant_src <= SRC_UART;
                rr_uart   <= 1'b0;
            end
        end
    end

    // FSM state register
    always_ff @(posedge clk_50MHz) begin
        if (!reset_n) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Arbitration and next-state logic; grants happen only from IDLE with the core ready
    always_comb begin
        grant_grav = 1'b0;
        grant_btn  = 1'b0;
        grant_uart = 1'b0;
        next_state = state;
        case (state)
            ST_IDLE: begin
                if (ready) begin
                    if (grav_pend) begin
                        grant_grav = 1'b1;
                    end else if (btn_full && (!uart_full || !rr_uart)) begin
                        grant_btn = 1'b1;
                    end else if (uart_full) begin
                        grant_uart = 1'b1;
                    end
                end
                if (grant_grav || grant_btn || grant_uart) begin
                    next_state = ST_ISSUE;
                end
            end
            ST_ISSUE: next_state = ST_WAIT;
            ST_WAIT: begin
                if (ready) begin
                    next_state = ST_IDLE;
                end
            end
            default: next_state = ST_IDLE;
        endcase
    end

    assign grant_any = grant_grav | grant_btn | grant_uart;

    // Outputs: ctrl carries the code only during the single ISSUE cycle
    always_comb begin
        ctrl = '0;
        busy = 1'b0;
        if (state == ST_ISSUE) begin
            ctrl = cmd_q;
        end
        if (state != ST_IDLE) begin
            busy = 1'b1;
        end
    end

endmodule
